pe_feeder: RTL
==============

# pe_feeder

Drives the input side of a PE: converts a tile command plus a valid/ready stream of per-row operands into the PE's free-running input stream. It generates `in_a`, `in_b`, `in_d`, dataflow, propagate, shift, id, last and valid. It sits at the west/north edge of a PE row/column and is the transmitter for the PE's control protocol. Its main job is toggling propagate exactly once per tile so the PE's flip detection, and with it the accumulator swap and output shift, fires on the first beat of each tile.

## Interface
- `INPUT_W`, 8, width of the a operand
- `OUTPUT_W`, 20, width of the b and d operands
- `ROWS_W`, 4, width of the tile row count; max tile = 2^ROWS_W − 1 rows
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `cmd_valid` / `cmd_ready` in / out, 1 each: tile command handshake
- `cmd_dataflow` in 1: 0 = output-stationary, 1 = weight-stationary
- `cmd_shift` in 5: rounding shift applied by the PE on flip
- `cmd_id` in 3: tile tag
- `cmd_rows` in ROWS_W: beats in the tile, legal range 1..max
- `data_valid` / `data_ready` in / out, 1 each: operand beat handshake
- `data_a` in INPUT_W, `data_b` in OUTPUT_W, `data_d` in OUTPUT_W: operands for one beat
- `pe_a` out INPUT_W, `pe_b` out OUTPUT_W, `pe_d` out OUTPUT_W: registered operands to the PE
- `pe_control_dataflow`, `pe_control_propagate` out 1 each; `pe_control_shift` out 5; `pe_id` out 3: registered control
- `pe_last` out 1: final beat of the tile
- `pe_valid` out 1: beat strobe; the PE updates state only when this is high
- `busy` out 1: a tile is in progress
- `bad_cmd` out 1: sticky; set when a command arrives with `cmd_rows == 0`

## Operation
- State machine: IDLE and STREAM.
- IDLE:
  - `cmd_ready = 1`, `data_ready = 0`.
  - On a command fire with `cmd_rows != 0`: latch dataflow, shift, id and rows; toggle the internal `prop` bit; clear the beat counter; go to STREAM.
  - On a command fire with `cmd_rows == 0`: set `bad_cmd`; no toggle; stay in IDLE.
- STREAM:
  - `data_ready = 1`.
  - Each data fire emits one PE beat on the next edge. Operands come from the data port. Control comes from the latched command with propagate = `prop`. `pe_last = (cnt == rows−1)`. The counter increments.
  - When the last beat fires, go to IDLE.
- Back-to-back tiles: during STREAM, `cmd_ready = data_valid && (cnt == rows−1)`. A command accepted in the same cycle as the last beat is latched and toggles `prop`, and the FSM stays in STREAM with the counter cleared. Its first beat may fire the very next cycle, so no bubble is required.
- Bubbles:
  - If `data_valid` is low in STREAM, the next cycle has `pe_valid = 0` and `pe_last = 0`.
  - All other PE outputs hold their last values. The PE ignores them, and holding them saves toggling.
- The PE has no backpressure; the feeder never stalls on the PE side.
- Width rules: operands pass through unmodified, with no sign extension or truncation here. `cmd_shift` is forwarded verbatim for the whole tile.
- `busy = (state == STREAM)`.
- `bad_cmd` clears only on reset.

## Timing
- Latency: a data fire at edge N produces `pe_valid = 1` for cycle N+1. Throughput is 1 beat/cycle.
- Reset values:
  - State IDLE, `prop = 0`, counter 0, latched command fields 0.
  - All `pe_*` outputs 0, `busy = 0`, `bad_cmd = 0`.
  - `cmd_ready = 1` from the first cycle after reset; `data_ready = 0`.
- The first tile after reset streams with propagate = 1; the second with 0; and so on.
- Reset mid-tile: the next edge returns everything to reset values; the partial tile is discarded and `pe_valid` drops the following cycle.
- Every `pe_*` output is a flop; no combinational path runs from inputs to `pe_*`. `cmd_ready` and `data_ready` are combinational from state, counter and `data_valid` only.
- Simultaneous last-beat data fire and command fire: both are accepted in the same cycle; the last beat carries the old `prop`, and the next tile carries the toggled one.

## Structure
- Shared package `pe_pkg`:
  - `df_t` enum (OS = 1'b0, WS = 1'b1) and `feed_state_t` (IDLE, STREAM).
  - Shift width constant 5 and id width constant 3, shared with the PE.
- Single module; no sub-module is warranted. The counter and FSM live in the same process.

## Test plan
- Reset, then `cmd{df=0, shift=3, id=5, rows=4}` and 4 back-to-back data beats with a = 1..4 → `pe_valid` high for 4 consecutive cycles starting one cycle after the first fire; propagate = 1 throughout; `pe_last` only on the 4th beat; `pe_control_shift = 3`; `pe_id = 5`.
- Second command with `rows=2` → propagate = 0 on both beats; a third command → propagate = 1.
- Data beats with gaps (valid 1,0,0,1,1 for `rows=3`) → `pe_valid` pattern 1,0,0,1,1 delayed one cycle; `pe_a` holds during the gaps; `pe_last` coincides with the final valid beat.
- Command for the next tile presented during the last beat of the current tile → accepted that cycle; the new tile's first beat can follow with no idle cycle; propagate alternates between the two tiles.
- `cmd_rows = 0` → `bad_cmd` rises and stays high; no `pe_valid`; the next legal command still toggles propagate from its prior value.
- Reset asserted after 2 of 4 beats → next cycle all `pe_*` are 0, `busy = 0`; the following tile starts with propagate = 1.

Source files
------------

// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Types and constants shared between the PE and the blocks that feed it.
//   df_t          : dataflow selector (OS = output-stationary,
//                   WS = weight-stationary)
//   feed_state_t  : pe_feeder state encoding
//   SHIFT_W, ID_W : widths of the rounding-shift and tile-tag fields
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int SHIFT_W = 5;
    localparam int ID_W    = 3;

    typedef enum logic {
        OS = 1'b0,
        WS = 1'b1
    } df_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } feed_state_t;

endpackage

// File: rtl/pe_feeder.sv
// ---------------------------------------------------------------------------
// pe_feeder
// Turns a tile command plus a valid/ready stream of per-row operands into the
// PE's free-running input stream. It toggles propagate once per tile, so the
// PE sees a flip on the first beat of every tile.
//
// Ports
//   clock, reset                 : single clock; synchronous active-high reset
//   cmd_valid / cmd_ready        : tile command handshake
//   cmd_dataflow, cmd_shift,
//   cmd_id, cmd_rows             : tile command fields (rows legal 1..max)
//   data_valid / data_ready      : operand beat handshake
//   data_a, data_b, data_d       : operands for one beat
//   pe_a, pe_b, pe_d             : registered operands to the PE
//   pe_control_dataflow,
//   pe_control_propagate,
//   pe_control_shift, pe_id      : registered control to the PE
//   pe_last                      : final beat of the tile
//   pe_valid                     : beat strobe
//   busy                         : a tile is in progress
//   bad_cmd                      : sticky; a zero-row command was received
// ---------------------------------------------------------------------------
module pe_feeder
    import pe_pkg::*;
#(
    parameter int INPUT_W  = 8,
    parameter int OUTPUT_W = 20,
    parameter int ROWS_W   = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dataflow,
    input  logic [SHIFT_W-1:0]  cmd_shift,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ROWS_W-1:0]   cmd_rows,

    input  logic                data_valid,
    output logic                data_ready,
    input  logic [INPUT_W-1:0]  data_a,
    input  logic [OUTPUT_W-1:0] data_b,
    input  logic [OUTPUT_W-1:0] data_d,

    output logic [INPUT_W-1:0]  pe_a,
    output logic [OUTPUT_W-1:0] pe_b,
    output logic [OUTPUT_W-1:0] pe_d,
    output logic                pe_control_dataflow,
    output logic                pe_control_propagate,
    output logic [SHIFT_W-1:0]  pe_control_shift,
    output logic [ID_W-1:0]     pe_id,
    output logic                pe_last,
    output logic                pe_valid,

    output logic                busy,
    output logic                bad_cmd
);

    feed_state_t         state_reg;
    logic                prop_reg;
    logic [ROWS_W-1:0]   cnt_reg;
    logic [ROWS_W-1:0]   rows_reg;
    df_t                 df_reg;
    logic [SHIFT_W-1:0]  shift_reg;
    logic [ID_W-1:0]     id_reg;

    logic [ROWS_W-1:0]   rows_m1;
    logic                last_beat;
    logic                data_fire;
    logic                cmd_fire;
    logic                cmd_accept;

    assign rows_m1   = rows_reg - ROWS_W'(1);
    assign last_beat = (cnt_reg == rows_m1);

    // A new command is only taken mid-stream together with the tile's last
    // beat, which lets consecutive tiles run without an idle cycle.
    assign cmd_ready  = (state_reg == IDLE) ? 1'b1 : (data_valid && last_beat);
    assign data_ready = (state_reg == STREAM);
    assign busy       = (state_reg == STREAM);

    assign data_fire  = data_valid && data_ready;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cmd_accept = cmd_fire && (cmd_rows != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg            <= IDLE;
            prop_reg             <= 1'b0;
            cnt_reg              <= '0;
            rows_reg             <= '0;
            df_reg               <= OS;
            shift_reg            <= '0;
            id_reg               <= '0;
            pe_a                 <= '0;
            pe_b                 <= '0;
            pe_d                 <= '0;
            pe_control_dataflow  <= 1'b0;
            pe_control_propagate <= 1'b0;
            pe_control_shift     <= '0;
            pe_id                <= '0;
            pe_last              <= 1'b0;
            pe_valid             <= 1'b0;
            bad_cmd              <= 1'b0;
        end else begin
            // Strobes drop on bubbles; operands and control hold their last
            // values to avoid needless toggling into the PE.
            pe_valid <= 1'b0;
            pe_last  <= 1'b0;

            if (data_fire) begin
                pe_a                 <= data_a;
                pe_b                 <= data_b;
                pe_d                 <= data_d;
                pe_control_dataflow  <= df_reg;
                pe_control_propagate <= prop_reg;
                pe_control_shift     <= shift_reg;
                pe_id                <= id_reg;
                pe_last              <= last_beat;
                pe_valid             <= 1'b1;
                cnt_reg              <= cnt_reg + ROWS_W'(1);
                if (last_beat) begin
                    state_reg <= IDLE;
                end
            end

            if (cmd_fire && (cmd_rows == '0)) begin
                bad_cmd <= 1'b1;
            end

            // Placed after the beat logic so an accept coinciding with the
            // last beat overrides the return to IDLE and the counter update.
            // The outgoing beat above still uses the old latched fields.
            if (cmd_accept) begin
                df_reg    <= df_t'(cmd_dataflow);
                shift_reg <= cmd_shift;
                id_reg    <= cmd_id;
                rows_reg  <= cmd_rows;
                prop_reg  <= ~prop_reg;
                cnt_reg   <= '0;
                state_reg <= STREAM;
            end
        end
    end

endmodule
